// File: rtl/wishbone_cfg_master.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// wishbone_cfg_master : Wishbone classic initiator expanding CGRA config commands into CSR beats
// Revision            : 1.0 - initial release
// ------------------------------------------------------------------------------------------
module wishbone_cfg_master #(
   parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
   parameter int unsigned READ_WAIT          = 4,
   parameter int unsigned ACK_TIMEOUT        = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        busy_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   localparam logic [1:0] c_op_write = 2'b00;
   localparam logic [1:0] c_op_read  = 2'b01;
   localparam logic [1:0] c_op_rsvd  = 2'b11;

   localparam logic [7:0] c_off_addr  = 8'h00;
   localparam logic [7:0] c_off_wdata = 8'h04;
   localparam logic [7:0] c_off_rdata = 8'h08;
   localparam logic [7:0] c_off_write = 8'h0C;
   localparam logic [7:0] c_off_read  = 8'h10;
   localparam logic [7:0] c_off_stall = 8'h14;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BEAT = 3'd1,
      S_GAP  = 3'd2,
      S_WAIT = 3'd3,
      S_RESP = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [31:0] r_rd_data;
   logic [31:0] r_rsp_data;
   logic [31:0] r_cnt;
   logic [2:0]  r_step;
   logic        r_err;

   logic [7:0]  w_off;
   logic [31:0] w_dat;
   logic        w_we;
   logic [1:0]  w_last;
   logic        w_in_beat;
   logic        w_ack;

   assign w_in_beat = (r_state == S_BEAT);
   assign w_ack     = w_in_beat & wbm_ack_i;

   // Beat table: register offset, write data and direction for the current step of the command
   always_comb begin
      w_off  = c_off_stall;
      w_dat  = 32'd0;
      w_we   = 1'b1;
      w_last = 2'd0;
      case (r_op)
         c_op_write: begin
            w_last = 2'd2;
            case (r_step)
               3'd0:    begin w_off = c_off_addr;  w_dat = r_addr; end
               3'd1:    begin w_off = c_off_wdata; w_dat = r_data; end
               default: begin w_off = c_off_write; w_dat = 32'd1;  end
            endcase
         end
         c_op_read: begin
            w_last = 2'd3;
            case (r_step)
               3'd0:    begin w_off = c_off_addr;  w_dat = r_addr; end
               3'd1:    begin w_off = c_off_read;  w_dat = 32'd1;  end
               3'd2:    begin w_off = c_off_rdata; w_we  = 1'b0;   end
               default: begin w_off = c_off_read;  w_dat = 32'd0;  end
            endcase
         end
         default: begin
            w_off = c_off_stall;
            w_dat = {28'd0, r_data[3:0]};
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid_i) begin
               w_next = (cmd_op_i == c_op_rsvd) ? S_RESP : S_BEAT;
            end
         end
         S_BEAT: begin
            if (w_ack) begin
               w_next = S_GAP;
            end else if (r_cnt == ACK_TIMEOUT - 32'd1) begin
               w_next = S_RESP;
            end
         end
         S_GAP: begin
            if (r_step > {1'b0, w_last}) begin
               w_next = S_RESP;
            end else if ((r_op == c_op_read) && (r_step == 3'd2) && (READ_WAIT != 0)) begin
               w_next = S_WAIT;
            end else begin
               w_next = S_BEAT;
            end
         end
         S_WAIT: begin
            if (r_cnt == READ_WAIT - 32'd1) begin
               w_next = S_BEAT;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state    <= S_IDLE;
         r_op       <= 2'd0;
         r_addr     <= 32'd0;
         r_data     <= 32'd0;
         r_rd_data  <= 32'd0;
         r_rsp_data <= 32'd0;
         r_cnt      <= 32'd0;
         r_step     <= 3'd0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         // One counter serves both the ack timeout and the read wait; it restarts on every state change
         if (r_state != w_next) begin
            r_cnt <= 32'd0;
         end else if ((r_state == S_BEAT) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + 32'd1;
         end
         if ((r_state == S_IDLE) && cmd_valid_i) begin
            r_op      <= cmd_op_i;
            r_addr    <= cmd_addr_i;
            r_data    <= cmd_data_i;
            r_step    <= 3'd0;
            r_rd_data <= 32'd0;
            r_err     <= (cmd_op_i == c_op_rsvd);
         end
         if (w_ack) begin
            r_step <= r_step + 3'd1;
            if ((r_op == c_op_read) && (r_step == 3'd2)) begin
               r_rd_data <= wbm_dat_i;
            end
         end
         if ((r_state == S_BEAT) && (w_next == S_RESP)) begin
            r_err <= 1'b1;
         end
         if ((w_next == S_RESP) && (r_state != S_RESP)) begin
            r_rsp_data <= ((r_state != S_IDLE) && (r_op == c_op_read)) ? r_rd_data : 32'd0;
         end
      end
   end

   assign cmd_ready_o = (r_state == S_IDLE) & ~wb_rst_i;
   assign busy_o      = (r_state != S_IDLE);
   assign rsp_valid_o = (r_state == S_RESP);
   assign rsp_err_o   = rsp_valid_o & r_err;
   assign rsp_data_o  = r_rsp_data;

   assign wbm_cyc_o = w_in_beat;
   assign wbm_stb_o = w_in_beat;
   assign wbm_we_o  = w_in_beat & w_we;
   assign wbm_sel_o = w_in_beat ? 4'hF : 4'h0;
   assign wbm_adr_o = w_in_beat ? (WISHBONE_BASE_ADDR + {24'd0, w_off}) : 32'd0;
   assign wbm_dat_o = w_in_beat ? w_dat : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_cfg_master.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// tb_wishbone_cfg_master : directed bench for wishbone_cfg_master with a delay-programmable WB slave
// Revision               : 1.0 - initial release
// ------------------------------------------------------------------------------------------
module tb_wishbone_cfg_master;

   localparam logic [31:0] c_base = 32'h3000_0000;

   logic        wb_clk_i    = 1'b0;
   logic        wb_rst_i    = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic [1:0]  cmd_op_i    = 2'd0;
   logic [31:0] cmd_addr_i  = 32'd0;
   logic [31:0] cmd_data_i  = 32'd0;
   logic        cmd_ready_o;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic        busy_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wishbone_cfg_master #(
      .WISHBONE_BASE_ADDR (32'h3000_0000),
      .READ_WAIT          (4),
      .ACK_TIMEOUT        (16)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_data_i  (cmd_data_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack_i)
   );

   // Slave: acks once stb has been held for slv_dly cycles (0 = same cycle), or never
   int          slv_dly   = 0;
   bit          slv_never = 1'b0;
   logic [31:0] slv_rdata = 32'd0;
   int          stb_cnt   = 0;

   always @(posedge wb_clk_i) stb_cnt <= (wbm_cyc_o && wbm_stb_o) ? stb_cnt + 1 : 0;
   assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !slv_never && (stb_cnt >= slv_dly);
   assign wbm_dat_i = (wbm_adr_o == c_base + 32'h8) ? slv_rdata : 32'hFFFF_FFFF;

   // Monitors sample mid-cycle; cyc_n = k during the cycle that follows clock edge k
   int          cyc_n = 0;
   logic [31:0] bt_adr[$];
   logic [31:0] bt_dat[$];
   logic        bt_we[$];
   logic [3:0]  bt_sel[$];
   int          bt_cyc[$];
   int          acc_cyc[$];
   int          rsp_cyc[$];
   logic [31:0] rsp_dat[$];
   logic        rsp_err[$];
   int          stb_cycles    = 0;
   int          stb_starts    = 0;
   int          ready_in_resp = 0;
   logic        prev_stb      = 1'b0;

   always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

   always @(negedge wb_clk_i) begin
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
         bt_adr.push_back(wbm_adr_o);
         bt_dat.push_back(wbm_dat_o);
         bt_we.push_back(wbm_we_o);
         bt_sel.push_back(wbm_sel_o);
         bt_cyc.push_back(cyc_n);
      end
      if (cmd_valid_i && cmd_ready_o) acc_cyc.push_back(cyc_n);
      if (rsp_valid_o) begin
         rsp_cyc.push_back(cyc_n);
         rsp_dat.push_back(rsp_data_o);
         rsp_err.push_back(rsp_err_o);
         if (cmd_ready_o) ready_in_resp++;
      end
      if (wbm_stb_o) begin
         stb_cycles++;
         if (!prev_stb) stb_starts++;
      end
      prev_stb = wbm_stb_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [31:0] adr,
                           input logic [31:0] dat, input logic we);
      check({tag, "_adr"}, bt_adr[idx], adr);
      check({tag, "_dat"}, bt_dat[idx], dat);
      check({tag, "_we"},  {31'd0, bt_we[idx]}, {31'd0, we});
      check({tag, "_sel"}, {28'd0, bt_sel[idx]}, 32'h0000_000F);
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
      bit ok;
      ok = 1'b0;
      @(posedge wb_clk_i); #1;
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_addr_i  = a;
      cmd_data_i  = d;
      for (int i = 0; i < 100 && !ok; i++) begin
         ok = cmd_ready_o;
         @(posedge wb_clk_i); #1;
      end
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'b11;
      cmd_addr_i  = ~a;
      cmd_data_i  = ~d;
      check("accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 300 && rsp_cyc.size() < n; i++) begin
         @(posedge wb_clk_i); #1;
      end
      check("rsp_count", 32'(rsp_cyc.size()), 32'(n));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, na, nr, s0, sc0;

      #12;
      check("rst_ctrl", {25'd0, cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o,
                         wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
      check("rst_bus", wbm_adr_o | wbm_dat_o | {28'd0, wbm_sel_o} | rsp_data_o, 32'd0);
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      #1;
      check("idle_ready_busy", {30'd0, cmd_ready_o, busy_o}, 32'd2);

      // Config write, immediate-ack slave
      nb = bt_adr.size(); na = acc_cyc.size(); nr = rsp_cyc.size();
      send(2'b00, 32'h0000_0104, 32'hDEAD_BEEF);
      wait_rsp(nr + 1);
      check("w_nbeats", 32'(bt_adr.size() - nb), 32'd3);
      chk_beat("w_b0", nb,     c_base + 32'h00, 32'h0000_0104, 1'b1);
      chk_beat("w_b1", nb + 1, c_base + 32'h04, 32'hDEAD_BEEF, 1'b1);
      chk_beat("w_b2", nb + 2, c_base + 32'h0C, 32'h0000_0001, 1'b1);
      check("w_first", 32'(bt_cyc[nb] - acc_cyc[na]), 32'd1);
      check("w_gap01", 32'(bt_cyc[nb + 1] - bt_cyc[nb]), 32'd2);
      check("w_gap12", 32'(bt_cyc[nb + 2] - bt_cyc[nb + 1]), 32'd2);
      check("w_latency", 32'(rsp_cyc[nr] - acc_cyc[na]), 32'd7);
      check("w_err", {31'd0, rsp_err[nr]}, 32'd0);
      check("w_data", rsp_dat[nr], 32'd0);

      // Config read with READ_WAIT idle cycles before the RDATA beat
      slv_rdata = 32'h1234_5678;
      nb = bt_adr.size(); na = acc_cyc.size(); nr = rsp_cyc.size();
      send(2'b01, 32'h0000_0020, 32'h0);
      wait_rsp(nr + 1);
      check("r_nbeats", 32'(bt_adr.size() - nb), 32'd4);
      chk_beat("r_b0", nb,     c_base + 32'h00, 32'h0000_0020, 1'b1);
      chk_beat("r_b1", nb + 1, c_base + 32'h10, 32'h0000_0001, 1'b1);
      chk_beat("r_b2", nb + 2, c_base + 32'h08, 32'h0000_0000, 1'b0);
      chk_beat("r_b3", nb + 3, c_base + 32'h10, 32'h0000_0000, 1'b1);
      check("r_wait_gap", 32'(bt_cyc[nb + 2] - bt_cyc[nb + 1]), 32'd6);
      check("r_latency", 32'(rsp_cyc[nr] - acc_cyc[na]), 32'd13);
      check("r_data", rsp_dat[nr], 32'h1234_5678);
      check("r_err", {31'd0, rsp_err[nr]}, 32'd0);
      repeat (3) @(posedge wb_clk_i);
      #1;
      check("r_data_held", rsp_data_o, 32'h1234_5678);

      // Stall updates: value 0, then only the low nibble of a wider word
      nb = bt_adr.size(); na = acc_cyc.size(); nr = rsp_cyc.size();
      send(2'b10, 32'h0, 32'h0);
      wait_rsp(nr + 1);
      check("s0_nbeats", 32'(bt_adr.size() - nb), 32'd1);
      chk_beat("s0_b0", nb, c_base + 32'h14, 32'h0, 1'b1);
      check("s0_latency", 32'(rsp_cyc[nr] - acc_cyc[na]), 32'd3);
      check("s0_data", rsp_dat[nr], 32'd0);
      nb = bt_adr.size(); nr = rsp_cyc.size();
      send(2'b10, 32'h0, 32'hABCD_123F);
      wait_rsp(nr + 1);
      chk_beat("s1_b0", nb, c_base + 32'h14, 32'h0000_000F, 1'b1);

      // Slave never acks: the beat times out after ACK_TIMEOUT strobe cycles
      slv_never = 1'b1;
      nb = bt_adr.size(); na = acc_cyc.size(); nr = rsp_cyc.size();
      s0 = stb_starts; sc0 = stb_cycles;
      send(2'b00, 32'h0000_0300, 32'h0000_0055);
      wait_rsp(nr + 1);
      check("to_stb_cycles", 32'(stb_cycles - sc0), 32'd16);
      check("to_stb_starts", 32'(stb_starts - s0), 32'd1);
      check("to_nbeats", 32'(bt_adr.size() - nb), 32'd0);
      check("to_latency", 32'(rsp_cyc[nr] - acc_cyc[na]), 32'd17);
      check("to_err", {31'd0, rsp_err[nr]}, 32'd1);
      check("to_ready_back", {31'd0, cmd_ready_o}, 32'd1);
      slv_never = 1'b0;

      // Reserved op: no bus activity, error response the cycle after accept
      na = acc_cyc.size(); nr = rsp_cyc.size(); s0 = stb_starts;
      send(2'b11, 32'h0, 32'h0);
      wait_rsp(nr + 1);
      check("rsv_stb_starts", 32'(stb_starts - s0), 32'd0);
      check("rsv_latency", 32'(rsp_cyc[nr] - acc_cyc[na]), 32'd1);
      check("rsv_err", {31'd0, rsp_err[nr]}, 32'd1);

      // Asynchronous reset while a read sits in its wait window
      nr = rsp_cyc.size();
      send(2'b01, 32'h0000_0040, 32'h0);
      repeat (5) @(posedge wb_clk_i);
      #2;
      check("mid_in_wait", {30'd0, busy_o, wbm_stb_o}, 32'd2);
      wb_rst_i = 1'b1;
      #1;
      check("mid_rst_ctrl", {25'd0, cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o,
                             wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
      check("mid_rst_bus", wbm_adr_o | wbm_dat_o | {28'd0, wbm_sel_o} | rsp_data_o, 32'd0);
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      repeat (12) @(posedge wb_clk_i);
      #1;
      check("mid_no_rsp", 32'(rsp_cyc.size()), 32'(nr));
      nb = bt_adr.size(); nr = rsp_cyc.size();
      send(2'b10, 32'h0, 32'h0000_0005);
      wait_rsp(nr + 1);
      chk_beat("post_rst_b0", nb, c_base + 32'h14, 32'h0000_0005, 1'b1);
      check("post_rst_err", {31'd0, rsp_err[nr]}, 32'd0);

      // Slow slave plus cmd_valid held high: exactly one accept per response
      slv_dly = 3;
      nb = bt_adr.size(); na = acc_cyc.size(); nr = rsp_cyc.size();
      s0 = stb_starts; sc0 = stb_cycles;
      @(posedge wb_clk_i); #1;
      cmd_valid_i = 1'b1;
      cmd_op_i    = 2'b00;
      cmd_addr_i  = 32'h0000_0044;
      cmd_data_i  = 32'h5555_AAAA;
      for (int i = 0; i < 200 && rsp_cyc.size() < nr + 2; i++) begin
         @(posedge wb_clk_i); #1;
      end
      cmd_valid_i = 1'b0;
      repeat (2) @(posedge wb_clk_i);
      #1;
      check("hold_rsps", 32'(rsp_cyc.size() - nr), 32'd2);
      check("hold_accepts", 32'(acc_cyc.size() - na), 32'd2);
      check("hold_stb_starts", 32'(stb_starts - s0), 32'd6);
      check("hold_stb_cycles", 32'(stb_cycles - sc0), 32'd24);
      check("hold_nbeats", 32'(bt_adr.size() - nb), 32'd6);
      chk_beat("hold_b1", nb + 1, c_base + 32'h04, 32'h5555_AAAA, 1'b1);
      chk_beat("hold_b3", nb + 3, c_base + 32'h00, 32'h0000_0044, 1'b1);
      check("hold_latency", 32'(rsp_cyc[nr] - acc_cyc[na]), 32'd16);
      check("hold_b2b", 32'(acc_cyc[na + 1] - rsp_cyc[nr]), 32'd1);
      check("ready_in_resp", 32'(ready_in_resp), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
